// File: rtl/buffered_output_register_if.sv
// Bus-side and display-side signals of the buffered output register.
// The master drives loads and display readiness; the slave returns display data and FIFO status.
interface buffered_output_register_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         bus_input;
    logic                     L_O_bar;
    logic                     display_ready;
    logic [WIDTH-1:0]         display_output;
    logic                     display_strobe;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;

    modport master (
        output bus_input, L_O_bar, display_ready,
        input  display_output, display_strobe, full, empty, count, overflow
    );

    modport slave (
        input  bus_input, L_O_bar, display_ready,
        output display_output, display_strobe, full, empty, count, overflow
    );
endinterface

// File: rtl/buffered_output_register.sv
// FIFO-buffered display register: bus loads queue up and are released one word per ready cycle.
// No bypass path, so a word always spends at least one edge in storage.
module buffered_output_register #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic                        CLK,
    input logic                        CLR_bar,
    buffered_output_register_if.slave  bor
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] display_q;
    logic             strobe_q;
    logic             overflow_q;

    logic is_full;
    logic is_empty;
    logic pop;
    logic push;
    logic drop;

    assign is_full  = (cnt == CNT_W'(DEPTH));
    assign is_empty = (cnt == '0);
    assign pop      = bor.display_ready && !is_empty;
    // A full FIFO still accepts a load when the head leaves at the same edge.
    assign push     = !bor.L_O_bar && (!is_full || pop);
    assign drop     = !bor.L_O_bar && is_full && !pop;

    // Storage is left uncleared by reset; the pointers and count make stale words unreachable.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= bor.bus_input;
        end
    end

    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            display_q  <= '0;
            strobe_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            strobe_q <= pop;
            if (pop) begin
                display_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bor.display_output = display_q;
    assign bor.display_strobe = strobe_q;
    assign bor.full           = is_full;
    assign bor.empty          = is_empty;
    assign bor.count          = cnt;
    assign bor.overflow       = overflow_q;
endmodule
